vga_line_fetcher: RTL and testbench

Streams the framebuffer out of the external cellular RAM and feeds the VGA pixel pipeline. Sits directly downstream of `memory_controller`. It issues sequential 16-bit word reads over a single-outstanding req/ack handshake and buffers them in a small FIFO. It then hands out 8-bit pixels, two per word, on demand from the pixel timing logic.

---
 rtl/vga_line_fetcher_if.sv | 25 ++
 rtl/vga_line_fetcher.sv | 193 +++++++++++++++++++
 tb/tb_vga_line_fetcher.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_fetcher_if.sv
// Memory-side read bus between the line fetcher and the memory controller.
// One request outstanding at a time: mem_req is held until a one-cycle
// mem_ack, and mem_rdata is valid in the ack cycle.
interface vga_line_fetcher_if #(
    parameter int ADDR_W = 23
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/vga_line_fetcher.sv
// Streams framebuffer words out of cellular RAM into a small word FIFO and
// hands them to the pixel pipeline as 8-bit pixels, low byte first.
//
// state | meaning
// IDLE  | after reset, no requests, waiting for frame_start
// ISSUE | decide: frame complete, request next word, or wait for FIFO room
// REQ   | request outstanding, word is kept on ack
// DONE  | whole frame fetched, frame_done high, waiting for frame_start
// DRAIN | request outstanding across a restart, word is dropped on ack
module vga_line_fetcher #(
    parameter int                ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] FB_BASE     = '0,
    parameter int                FRAME_WORDS = 153600,
    parameter int                FIFO_DEPTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    vga_line_fetcher_if.master bus,
    input  logic               pix_rd,
    output logic [7:0]         pix_data,
    output logic               frame_done,
    output logic               underflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = (FRAME_WORDS < 1) ? 1 : $clog2(FRAME_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        REQ,
        DONE,
        DRAIN
    } fetchStateT;

    fetchStateT        state;
    fetchStateT        stateNext;
    logic [WCNT_W-1:0] wordCnt;
    logic [WCNT_W-1:0] wordCntNext;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  fifoCount;
    logic              hi;
    logic [15:0]       fifoMem [FIFO_DEPTH];
    logic [15:0]       headWord;

    logic              flush;
    logic              push;
    logic              pop;
    logic              pixAvail;
    logic              pixTake;
    logic              reqNext;
    logic              doneNext;

    assign pixAvail = (fifoCount != '0);
    assign pixTake  = pix_rd && pixAvail;
    assign pop      = pixTake && hi;
    assign headWord = fifoMem[rdPtr];

    // Next-state decode; frame_start always wins over the issue decision.
    always_comb begin
        stateNext = state;
        flush     = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    flush     = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (frame_start) begin
                    flush     = 1'b1;
                    stateNext = ISSUE;
                end else if (wordCnt == WCNT_W'(FRAME_WORDS)) begin
                    stateNext = DONE;
                end else if (fifoCount < CNT_W'(FIFO_DEPTH)) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                // The controller cannot cancel an access, so a restart
                // while waiting has to let the pending word come back first.
                if (frame_start) begin
                    flush     = 1'b1;
                    stateNext = bus.mem_ack ? ISSUE : DRAIN;
                end else if (bus.mem_ack) begin
                    push      = 1'b1;
                    stateNext = ISSUE;
                end
            end
            DONE: begin
                if (frame_start) begin
                    flush     = 1'b1;
                    stateNext = ISSUE;
                end
            end
            DRAIN: begin
                if (frame_start) begin
                    flush = 1'b1;
                end
                if (bus.mem_ack) begin
                    stateNext = ISSUE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Registered outputs and word counter follow directly from the next state.
    always_comb begin
        reqNext     = (stateNext == REQ) || (stateNext == DRAIN);
        doneNext    = (stateNext == DONE);
        wordCntNext = wordCnt;
        if (flush) begin
            wordCntNext = '0;
        end else if (push) begin
            wordCntNext = wordCnt + WCNT_W'(1);
        end
    end

    // State, handshake outputs, counters and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= FB_BASE;
            frame_done   <= 1'b0;
            underflow    <= 1'b0;
            wordCnt      <= '0;
            rdPtr        <= '0;
            wrPtr        <= '0;
            fifoCount    <= '0;
            hi           <= 1'b0;
        end else begin
            state       <= stateNext;
            bus.mem_req <= reqNext;
            frame_done  <= doneNext;
            wordCnt     <= wordCntNext;

            // Address only moves while no request is on the bus, so a
            // request drained across a restart keeps its original address.
            if (!reqNext) begin
                bus.mem_addr <= FB_BASE + ADDR_W'(wordCntNext);
            end

            if (pix_rd && !pixAvail) begin
                underflow <= 1'b1;
            end

            if (flush) begin
                rdPtr     <= '0;
                wrPtr     <= '0;
                fifoCount <= '0;
                hi        <= 1'b0;
            end else begin
                if (push) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (pop) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                if (pixTake) begin
                    hi <= ~hi;
                end
                unique case ({push, pop})
                    2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                    2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                    default: fifoCount <= fifoCount;
                endcase
            end
        end
    end

    // FIFO storage; room is guaranteed at issue time so a push never overwrites.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= bus.mem_rdata;
        end
    end

    // Pixel presented from the head word; zero while nothing is buffered.
    always_comb begin
        pix_data = 8'h00;
        if (pixAvail) begin
            pix_data = hi ? headWord[15:8] : headWord[7:0];
        end
    end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Bench for vga_line_fetcher: a memory responder with configurable latency
// plus a byte-queue reference model of the pixel stream, frame progress and
// the sticky underflow flag.
module tb_vga_line_fetcher;
    localparam int                ADDR_W      = 23;
    localparam logic [ADDR_W-1:0] FB_BASE     = 23'h7FFFF8;
    localparam int                FRAME_WORDS = 40;
    localparam int                FIFO_DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       pix_rd;
    logic [7:0] pix_data;
    logic       frame_done;
    logic       underflow;

    vga_line_fetcher_if #(.ADDR_W(ADDR_W)) bus ();

    vga_line_fetcher #(
        .ADDR_W      (ADDR_W),
        .FB_BASE     (FB_BASE),
        .FRAME_WORDS (FRAME_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .bus         (bus),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .frame_done  (frame_done),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  pixQ[$];
    logic [15:0] dataQ[$];
    int          wcntExp;
    bit          undExp, doneExp, doneArm;
    bit          pending, aborted, randLat;
    int          lat, cnt;
    int          acceptedCnt, reqCnt;
    logic [ADDR_W-1:0] reqAddr;
    bit          seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: responder decides its ack, inputs are driven, the edge is
    // taken, then the reference model advances and outputs are compared.
    task automatic step(input logic rd, input logic fs);
        logic              ackNow;
        logic [15:0]       d;
        logic [ADDR_W-1:0] ea;
        logic [7:0]        ep;
        logic [7:0]        junk;
        bit                accepted;
        ackNow = 1'b0;
        d      = 16'($urandom);
        if (rst_n) begin
            if (!pending && bus.mem_req === 1'b1) begin
                ea = FB_BASE + ADDR_W'(wcntExp);
                check("req_addr", 32'(bus.mem_addr), 32'(ea));
                pending = 1'b1;
                reqAddr = bus.mem_addr;
                reqCnt++;
                cnt = randLat ? int'($urandom_range(0, 4)) : lat;
            end else if (pending) begin
                check("req_held", 32'(bus.mem_req), 32'd1);
                check("addr_stable", 32'(bus.mem_addr), 32'(reqAddr));
            end
            if (pending && cnt == 0) begin
                ackNow = 1'b1;
                if (!aborted && !fs && dataQ.size() > 0) d = dataQ.pop_front();
            end
        end
        pix_rd        = rd;
        frame_start   = fs;
        bus.mem_ack   = ackNow;
        bus.mem_rdata = d;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pixQ.delete();
            wcntExp = 0;
            undExp  = 1'b0;
            doneExp = 1'b0;
            doneArm = 1'b0;
            pending = 1'b0;
            aborted = 1'b0;
        end else begin
            accepted = ackNow && !fs && !aborted;
            if (ackNow) begin
                pending = 1'b0;
                aborted = 1'b0;
            end else if (pending) begin
                cnt--;
            end
            if (rd) begin
                if (pixQ.size() == 0) undExp = 1'b1;
                else junk = pixQ.pop_front();
            end
            if (accepted) begin
                pixQ.push_back(d[7:0]);
                pixQ.push_back(d[15:8]);
                wcntExp++;
                acceptedCnt++;
            end
            if (doneArm) begin
                doneExp = 1'b1;
                doneArm = 1'b0;
            end
            if (accepted && wcntExp == FRAME_WORDS) doneArm = 1'b1;
            if (fs) begin
                pixQ.delete();
                wcntExp = 0;
                doneExp = 1'b0;
                doneArm = 1'b0;
                if (pending) aborted = 1'b1;
            end
        end
        ep = (pixQ.size() == 0) ? 8'h00 : pixQ[0];
        check("pix_data", 32'(pix_data), 32'(ep));
        check("underflow", 32'(underflow), 32'(undExp));
        check("frame_done", 32'(frame_done), 32'(doneExp));
    endtask

    initial begin
        rst_n         = 1'b0;
        frame_start   = 1'b0;
        pix_rd        = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        wcntExp = 0; undExp = 0; doneExp = 0; doneArm = 0;
        pending = 0; aborted = 0; randLat = 0; lat = 3; cnt = 0;
        acceptedCnt = 0; reqCnt = 0; reqAddr = '0;

        // reset values
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'(FB_BASE));
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        check("idle_no_req", 32'(bus.mem_req), 32'd0);

        // basic stream, ack 3 cycles into each request
        dataQ.push_back(16'hA1B2);
        dataQ.push_back(16'hC3D4);
        acceptedCnt = 0;
        step(1'b0, 1'b1);
        check("req_lat1", 32'(bus.mem_req), 32'd0);
        step(1'b0, 1'b0);
        check("req_lat2", 32'(bus.mem_req), 32'd1);
        for (int i = 0; i < 40 && acceptedCnt < 2; i++) step(1'b0, 1'b0);
        check("basic_acks", 32'(acceptedCnt), 32'd2);
        check("basic_px0", 32'(pix_data), 32'h0B2);
        step(1'b1, 1'b0);
        check("basic_px1", 32'(pix_data), 32'h0A1);
        step(1'b1, 1'b0);
        check("basic_px2", 32'(pix_data), 32'h0D4);
        step(1'b1, 1'b0);
        check("basic_px3", 32'(pix_data), 32'h0C3);
        step(1'b1, 1'b0);

        // FIFO full, then one word popped
        randLat = 1'b1;
        step(1'b0, 1'b1);
        acceptedCnt = 0;
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0);
        check("full_acks", 32'(acceptedCnt), 32'd16);
        check("full_no_req", 32'(bus.mem_req), 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            step(1'b0, 1'b0);
            if (bus.mem_req === 1'b1) seen = 1'b1;
        end
        check("full_rereq", 32'(seen), 32'd1);

        // frame end with continuous pixel reads
        step(1'b1, 1'b1);
        acceptedCnt = 0;
        reqCnt      = 0;
        for (int i = 0; i < 1500 && frame_done !== 1'b1; i++) step(1'b1, 1'b0);
        check("end_done", 32'(frame_done), 32'd1);
        check("end_acks", 32'(acceptedCnt), 32'(FRAME_WORDS));
        check("end_reqs", 32'(reqCnt), 32'(FRAME_WORDS));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            check("end_no_req", 32'(bus.mem_req), 32'd0);
        end
        step(1'b0, 1'b1);
        check("restart_done_clr", 32'(frame_done), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(1'b0, 1'b0);
            if (bus.mem_req === 1'b1) seen = 1'b1;
        end
        check("restart_req", 32'(seen), 32'd1);
        check("restart_addr", 32'(bus.mem_addr), 32'(FB_BASE));

        // abort mid-request, ack two cycles after the restart
        randLat = 1'b0;
        lat     = 3;
        step(1'b0, 1'b0);
        acceptedCnt = 0;
        step(1'b0, 1'b1);
        check("abort_req_held", 32'(bus.mem_req), 32'd1);
        for (int i = 0; i < 10 && pending; i++) step(1'b0, 1'b0);
        check("abort_drained", 32'(pending), 32'd0);
        check("abort_px", 32'(pix_data), 32'h000);
        check("abort_acc", 32'(acceptedCnt), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(1'b0, 1'b0);
            if (bus.mem_req === 1'b1) seen = 1'b1;
        end
        check("abort_rereq", 32'(seen), 32'd1);
        check("abort_addr", 32'(bus.mem_addr), 32'(FB_BASE));

        // reset while a request is on the bus
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        check("rst_mid_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_und", 32'(underflow), 32'd0);
        rst_n = 1'b1;

        // underflow before the first ack, sticky across a restart
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("und_set", 32'(underflow), 32'd1);
        check("und_px", 32'(pix_data), 32'h000);
        step(1'b0, 1'b1);
        check("und_sticky", 32'(underflow), 32'd1);
        for (int i = 0; i < 10 && pending; i++) step(1'b0, 1'b0);
        dataQ.push_back(16'h5A3C);
        acceptedCnt = 0;
        for (int i = 0; i < 20 && acceptedCnt < 1; i++) step(1'b0, 1'b0);
        check("und_lo", 32'(pix_data), 32'h03C);
        step(1'b1, 1'b0);
        check("und_hi", 32'(pix_data), 32'h05A);

        // push and pop in the same cycle with one word buffered
        lat = 4;
        step(1'b0, 1'b1);
        acceptedCnt = 0;
        for (int i = 0; i < 20 && acceptedCnt < 1; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 20 && !(pending && cnt == 0 && !aborted); i++) step(1'b0, 1'b0);
        dataQ.push_back(16'h9E71);
        step(1'b1, 1'b0);
        check("sim_px_lo", 32'(pix_data), 32'h071);
        step(1'b1, 1'b0);
        check("sim_px_hi", 32'(pix_data), 32'h09E);

        // randomized traffic against the model
        randLat = 1'b1;
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 299) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
